// File: rtl/fpu_uni_pkg.sv
// Shared widths and word layouts for the FPALU uni format and IEEE-754 binary32.
// Imported by the uni->IEEE output converter and its leading-zero counter.
package fpu_uni_pkg;

  localparam int UNI_EXP_W   = 6;
  localparam int UNI_MAN_W   = 22;
  localparam int LZC_W       = 5;
  localparam int IEEE_EXP_W  = 8;
  localparam int IEEE_FRAC_W = 23;
  localparam int IEEE_BIAS   = 127;

  typedef struct packed {
    logic                 sgn;
    logic [UNI_EXP_W-1:0] exp;
    logic [UNI_MAN_W-1:0] man_dn;
  } uni_t;

  typedef struct packed {
    logic                   sgn;
    logic [IEEE_EXP_W-1:0]  exp;
    logic [IEEE_FRAC_W-1:0] frac;
  } ieee32_t;

  function automatic ieee32_t ieee_signed_zero(input logic sgn);
    ieee32_t z;
    z      = '0;
    z.sgn  = sgn;
    return z;
  endfunction

endpackage : fpu_uni_pkg

// File: rtl/fpu_lzc22.sv
// Combinational 22-bit leading-zero counter with an all-zero flag.
// The count is 0 when the input is all zero; use zero_o to qualify it.
module fpu_lzc22
  import fpu_uni_pkg::*;
(
  input  logic [UNI_MAN_W-1:0] data_i,
  output logic [LZC_W-1:0]     cnt_o,
  output logic                 zero_o
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    cnt_o = '0;
    // Ascending scan: the highest set bit is the last one to write the count.
    for (int i = 0; i < UNI_MAN_W; i++) begin
      if (data_i[i]) cnt_o = LZC_W'(UNI_MAN_W - 1 - i);
    end
  end

  assign zero_o = (data_i == '0);

endmodule : fpu_lzc22

// File: rtl/fpu_uni2ieee.sv
// FPALU output converter: uni (sgn, 6-bit exp, 22-bit denormalised mantissa)
// to IEEE-754 binary32, as a 2-stage valid/ready pipeline (LZC, then pack).
module fpu_uni2ieee
  import fpu_uni_pkg::*;
#(
  parameter int unsigned UNI_BIAS = 31
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din_vld,
  output logic                 din_rdy,
  input  logic                 din_uni_sgn,
  input  logic [UNI_EXP_W-1:0] din_uni_exp,
  input  logic [UNI_MAN_W-1:0] din_uni_man_dn,
  output logic                 dout_vld,
  input  logic                 dout_rdy,
  output logic [31:0]          dout_ieee,
  output logic                 dout_zero
);

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic s1_vld_q;
  logic dout_vld_q;
  logic s1_adv;
  logic s2_adv;

  // din_rdy is combinational from dout_rdy, so a full pipe can take a new word
  // in the same cycle the output word is accepted.
  assign s2_adv  = !dout_vld_q || dout_rdy;
  assign s1_adv  = !s1_vld_q || s2_adv;
  assign din_rdy = s1_adv;

  // ---------------------------------------------------------------------------
  // Stage 1: capture the uni word together with its leading-zero count
  // ---------------------------------------------------------------------------
  uni_t             s1_d;
  uni_t             s1_q;
  logic [LZC_W-1:0] lzc_d;
  logic [LZC_W-1:0] s1_lzc_q;
  logic             zero_d;
  logic             s1_zero_q;

  assign s1_d = '{sgn: din_uni_sgn, exp: din_uni_exp, man_dn: din_uni_man_dn};

  fpu_lzc22 u_lzc (
    .data_i (din_uni_man_dn),
    .cnt_o  (lzc_d),
    .zero_o (zero_d)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_q      <= '0;
      s1_lzc_q  <= '0;
      s1_zero_q <= 1'b0;
    end else if (s1_adv) begin
      s1_vld_q  <= din_vld;
      s1_q      <= s1_d;
      s1_lzc_q  <= lzc_d;
      s1_zero_q <= zero_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: normalise and pack
  // ---------------------------------------------------------------------------
  logic [UNI_MAN_W-1:0]  man_sh;
  logic [IEEE_EXP_W-1:0] exp_d;
  ieee32_t               dout_d;
  ieee32_t               dout_ieee_q;
  logic                  dout_zero_q;

  // Shifting by lzc+1 drops the leading one, leaving the hidden-bit fraction.
  assign man_sh = s1_q.man_dn << ({1'b0, s1_lzc_q} + 6'd1);

  // The true exponent lies in 42..189 for any exp and bias in 0..63, so the
  // low 8 bits of the modular sum are exact and always a normal encoding.
  assign exp_d = IEEE_EXP_W'({2'b00, s1_q.exp})
               + IEEE_EXP_W'(IEEE_BIAS)
               - IEEE_EXP_W'(UNI_BIAS)
               - IEEE_EXP_W'({3'b000, s1_lzc_q})
               - IEEE_EXP_W'(1);

  always_comb begin
    dout_d = '{sgn: s1_q.sgn, exp: exp_d, frac: {man_sh, 1'b0}};
    if (s1_zero_q) dout_d = ieee_signed_zero(s1_q.sgn);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_vld_q  <= 1'b0;
      dout_ieee_q <= '0;
      dout_zero_q <= 1'b0;
    end else if (s2_adv) begin
      dout_vld_q  <= s1_vld_q;
      dout_ieee_q <= dout_d;
      dout_zero_q <= s1_zero_q;
    end
  end

  assign dout_vld  = dout_vld_q;
  assign dout_ieee = dout_ieee_q;
  assign dout_zero = dout_zero_q;

endmodule : fpu_uni2ieee
